// File: rtl/gpu_pkg.sv
// gpu_pkg: core-state and per-lane LSU state encodings shared by the GPU blocks
package gpu_pkg;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, search starting at ptr_i
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                    req_i,
    input  logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr_i,
    output logic [N-1:0]                    grant_o
);
    logic found;
    int   idx;
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/warp_lsu.sv
// warp_lsu: per-lane load/store unit funnelling all lanes through one shared
// memory read port and one shared write port, one request in flight at a time
module warp_lsu
    import gpu_pkg::*;
#(
    parameter int THREADS    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [2:0]                    core_state,
    input  logic                          mem_read_enable,
    input  logic                          mem_write_enable,
    input  logic [THREADS-1:0]            thread_mask,
    input  logic [THREADS*DATA_WIDTH-1:0] rs_data,
    input  logic [THREADS*DATA_WIDTH-1:0] rt_data,
    output logic                          mem_read_valid,
    output logic [ADDR_WIDTH-1:0]         mem_read_address,
    input  logic                          mem_read_ready,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    output logic                          mem_write_valid,
    output logic [ADDR_WIDTH-1:0]         mem_write_address,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic                          mem_write_ready,
    output logic [THREADS*DATA_WIDTH-1:0] lsu_out,
    output logic [2*THREADS-1:0]          lsu_state,
    output logic                          lsu_all_done
);
    localparam int PW = THREADS > 1 ? $clog2(THREADS) : 1;

    lsu_state_e                    st_q [THREADS];
    lsu_state_e                    st_d [THREADS];
    logic [THREADS-1:0]            rd_q, rd_d, req, gnt;
    logic [PW-1:0]                 rr_ptr_q, rr_ptr_d, cur_q, cur_d, gnt_idx;
    logic                          rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0]         wdata_q, wdata_d;
    logic [THREADS*DATA_WIDTH-1:0] out_q, out_d;
    logic                          start, upd, hs, issue, busy, all_ok, any_active;

    always_comb begin
        busy       = 1'b0;
        all_ok     = 1'b1;
        any_active = 1'b0;
        req        = '0;
        lsu_state  = '0;
        for (int i = 0; i < THREADS; i++) begin
            req[i]           = st_q[i] == LSU_REQUESTING;
            busy             = busy | (st_q[i] == LSU_WAITING);
            all_ok           = all_ok & ((st_q[i] == LSU_DONE) | ~thread_mask[i]);
            any_active       = any_active | (st_q[i] != LSU_IDLE);
            lsu_state[2*i+:2] = st_q[i];
        end
        lsu_all_done = all_ok & any_active;
    end

    rr_arbiter #(.N(THREADS)) u_arb (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < THREADS; i++)
            if (gnt[i]) gnt_idx = PW'(i);
    end

    // Valids are set from lane state, so a grant and a handshake never coincide
    always_comb begin
        start      = enable && core_state == CORE_REQUEST && (mem_read_enable || mem_write_enable);
        upd        = enable && core_state == CORE_UPDATE;
        hs         = enable && ((rd_valid_q && mem_read_ready) || (wr_valid_q && mem_write_ready));
        issue      = enable && !busy && |gnt;
        rd_d       = rd_q;
        rr_ptr_d   = rr_ptr_q;
        cur_d      = cur_q;
        rd_valid_d = rd_valid_q;
        wr_valid_d = wr_valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        out_d      = out_q;
        for (int i = 0; i < THREADS; i++) begin
            st_d[i] = st_q[i];
            if (st_q[i] == LSU_IDLE && start && thread_mask[i]) begin
                st_d[i] = LSU_REQUESTING;
                rd_d[i] = mem_read_enable;
            end
            if (st_q[i] == LSU_REQUESTING && issue && gnt[i]) st_d[i] = LSU_WAITING;
            if (st_q[i] == LSU_WAITING && hs) st_d[i] = LSU_DONE;
            if (st_q[i] == LSU_DONE && upd) st_d[i] = LSU_IDLE;
        end
        if (issue) begin
            cur_d      = gnt_idx;
            rr_ptr_d   = gnt_idx == PW'(THREADS - 1) ? '0 : gnt_idx + 1'b1;
            rd_valid_d = rd_q[gnt_idx];
            wr_valid_d = !rd_q[gnt_idx];
            addr_d     = rs_data[int'(gnt_idx)*DATA_WIDTH +: ADDR_WIDTH];
            wdata_d    = rt_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (hs) begin
            rd_valid_d = 1'b0;
            wr_valid_d = 1'b0;
            if (rd_valid_q) out_d[int'(cur_q)*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < THREADS; i++) st_q[i] <= LSU_IDLE;
            rd_q       <= '0;
            rr_ptr_q   <= '0;
            cur_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            out_q      <= '0;
        end else begin
            for (int i = 0; i < THREADS; i++) st_q[i] <= st_d[i];
            rd_q       <= rd_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_q      <= cur_d;
            rd_valid_q <= rd_valid_d;
            wr_valid_q <= wr_valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            out_q      <= out_d;
        end
    end

    assign mem_read_valid    = rd_valid_q;
    assign mem_read_address  = addr_q;
    assign mem_write_valid   = wr_valid_q;
    assign mem_write_address = addr_q;
    assign mem_write_data    = wdata_q;
    assign lsu_out           = out_q;
endmodule

// File: tb/tb_warp_lsu.sv
// tb_warp_lsu: directed scenarios for warp_lsu with hand-computed expectations
module tb_warp_lsu;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [2:0]  core_state = 3'b000;
    logic        mem_read_enable = 1'b0, mem_write_enable = 1'b0;
    logic [3:0]  thread_mask = 4'h0;
    logic [31:0] rs_data = '0, rt_data = '0;
    logic        mem_read_valid, mem_write_valid;
    logic [7:0]  mem_read_address, mem_write_address, mem_write_data;
    logic        mem_read_ready = 1'b0, mem_write_ready = 1'b0;
    logic [7:0]  mem_read_data = '0;
    logic [31:0] lsu_out;
    logic [7:0]  lsu_state;
    logic        lsu_all_done;
    int checks = 0, errors = 0;

    warp_lsu #(.THREADS(4), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .thread_mask(thread_mask), .rs_data(rs_data), .rt_data(rt_data),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_out(lsu_out), .lsu_state(lsu_state), .lsu_all_done(lsu_all_done)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_update;
        core_state = 3'b110;
        tick();
        core_state = 3'b000;
        checks++;
        if (lsu_state !== 8'h00) begin
            errors++;
            $display("FAIL update_idle: lsu_state=%h expected 00", lsu_state);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #12;
        checks++;
        if (lsu_state !== 8'h00 || mem_read_valid !== 1'b0 || mem_write_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: st=%h rv=%b wv=%b expected 00 0 0", lsu_state, mem_read_valid, mem_write_valid);
        end
        checks++;
        if (lsu_out !== 32'h0 || mem_read_address !== 8'h0 || mem_write_data !== 8'h0 || lsu_all_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: out=%h addr=%h wd=%h ad=%b expected zeros", lsu_out, mem_read_address, mem_write_data, lsu_all_done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_four;
        thread_mask = 4'hF; rs_data = 32'h13121110; rt_data = 32'h0D0C0B0A;
        mem_write_enable = 1'b1; mem_write_ready = 1'b1; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_write_enable = 1'b0;
        checks++;
        if (lsu_state !== 8'h55) begin
            errors++;
            $display("FAIL w4_requesting: lsu_state=%h expected 55", lsu_state);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (mem_write_valid !== 1'b1 || mem_write_address !== 8'h10 + 8'(k) || mem_write_data !== 8'h0A + 8'(k) || mem_read_valid !== 1'b0) begin
                errors++;
                $display("FAIL w4_write%0d: wv=%b addr=%h data=%h rv=%b expected 1 %h %h 0", k, mem_write_valid,
                         mem_write_address, mem_write_data, mem_read_valid, 8'h10 + 8'(k), 8'h0A + 8'(k));
            end
            tick();
        end
        checks++;
        if (lsu_state !== 8'hFF || lsu_all_done !== 1'b1 || mem_write_valid !== 1'b0) begin
            errors++;
            $display("FAIL w4_done: st=%h ad=%b wv=%b expected FF 1 0", lsu_state, lsu_all_done, mem_write_valid);
        end
        do_update();
    endtask

    task automatic test_single_read;
        thread_mask = 4'b0001; rs_data = 32'h00000020; mem_read_data = 8'hFF;
        mem_read_enable = 1'b1; mem_read_ready = 1'b1; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_read_enable = 1'b0;
        checks++;
        if (lsu_state !== 8'h01 || mem_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_request: st=%h rv=%b expected 01 0", lsu_state, mem_read_valid);
        end
        tick();
        checks++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h20 || lsu_state !== 8'h02) begin
            errors++;
            $display("FAIL rd_grant: rv=%b addr=%h st=%h expected 1 20 02", mem_read_valid, mem_read_address, lsu_state);
        end
        tick();
        checks++;
        if (lsu_state !== 8'h03 || lsu_out[7:0] !== 8'hFF || lsu_all_done !== 1'b1 || mem_read_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: st=%h out=%h ad=%b rv=%b expected 03 FF 1 0", lsu_state, lsu_out[7:0], lsu_all_done, mem_read_valid);
        end
        do_update();
        checks++;
        if (lsu_out[7:0] !== 8'hFF || lsu_all_done !== 1'b0) begin
            errors++;
            $display("FAIL rd_retain: out=%h ad=%b expected FF 0", lsu_out[7:0], lsu_all_done);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] order [4];
        order[0] = 8'h12; order[1] = 8'h13; order[2] = 8'h10; order[3] = 8'h11;
        thread_mask = 4'b0010; rs_data = 32'h00005500; mem_read_data = 8'h77;
        mem_read_enable = 1'b1; mem_read_ready = 1'b1; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_read_enable = 1'b0;
        tick();
        checks++;
        if (mem_read_address !== 8'h55 || mem_read_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_lane1: addr=%h rv=%b expected 55 1", mem_read_address, mem_read_valid);
        end
        tick();
        checks++;
        if (lsu_out[15:8] !== 8'h77 || lsu_out[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL rr_lane1_data: out=%h expected 77 in lane1, FF in lane0", lsu_out);
        end
        do_update();
        thread_mask = 4'hF; rs_data = 32'h13121110; rt_data = 32'h0D0C0B0A;
        mem_write_enable = 1'b1; mem_write_ready = 1'b1; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_write_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (mem_write_valid !== 1'b1 || mem_write_address !== order[k]) begin
                errors++;
                $display("FAIL rr_order%0d: wv=%b addr=%h expected 1 %h", k, mem_write_valid, mem_write_address, order[k]);
            end
            tick();
        end
        do_update();
    endtask

    task automatic test_backpressure;
        thread_mask = 4'b0001; rs_data = 32'h00000040; mem_read_data = 8'h99;
        mem_read_enable = 1'b1; mem_read_ready = 1'b0; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_read_enable = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h40 || lsu_state !== 8'h02) begin
                errors++;
                $display("FAIL bp_hold%0d: rv=%b addr=%h st=%h expected 1 40 02", k, mem_read_valid, mem_read_address, lsu_state);
            end
            tick();
        end
        mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        checks++;
        if (lsu_state !== 8'h03 || mem_read_valid !== 1'b0 || lsu_out[7:0] !== 8'h99) begin
            errors++;
            $display("FAIL bp_done: st=%h rv=%b out=%h expected 03 0 99", lsu_state, mem_read_valid, lsu_out[7:0]);
        end
        do_update();
    endtask

    task automatic test_both_enables;
        thread_mask = 4'b0001; rs_data = 32'h00000030; mem_read_data = 8'h5A;
        mem_read_enable = 1'b1; mem_write_enable = 1'b1;
        mem_read_ready = 1'b1; mem_write_ready = 1'b1; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        tick();
        checks++;
        if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== 8'h30) begin
            errors++;
            $display("FAIL both_read: rv=%b wv=%b addr=%h expected 1 0 30", mem_read_valid, mem_write_valid, mem_read_address);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (mem_read_valid !== 1'b1 || lsu_state !== 8'h02) begin
            errors++;
            $display("FAIL enable_hold: rv=%b st=%h expected 1 02", mem_read_valid, lsu_state);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (lsu_state !== 8'h03 || lsu_out[7:0] !== 8'h5A || mem_write_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_done: st=%h out=%h wv=%b expected 03 5A 0", lsu_state, lsu_out[7:0], mem_write_valid);
        end
        do_update();
    endtask

    task automatic test_reset_mid;
        thread_mask = 4'b0001; rs_data = 32'h00000060; mem_read_data = 8'h33;
        mem_read_enable = 1'b1; mem_read_ready = 1'b0; core_state = 3'b011;
        tick();
        core_state = 3'b000; mem_read_enable = 1'b0;
        tick();
        checks++;
        if (mem_read_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_valid: rv=%b expected 1", mem_read_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_read_valid !== 1'b0 || lsu_state !== 8'h00 || lsu_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: rv=%b st=%h out=%h expected 0 00 0", mem_read_valid, lsu_state, lsu_out);
        end
        tick();
        reset = 1'b1;
        mem_read_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_read_valid !== 1'b0 || lsu_state !== 8'h00 || lsu_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_late_ready: rv=%b st=%h out=%h expected 0 00 0", mem_read_valid, lsu_state, lsu_out);
        end
    endtask

    initial begin
        test_reset();
        test_write_four();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_both_enables();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
